// File: rtl/mem_arbiter_if.sv
// Bundle of request, completion and memory-port signals for mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// view of whatever surrounds it: the clients and the memory controller.
interface mem_arbiter_if #(
   parameter int XLEN = 32,
   parameter int DLEN = 32
);
   // instruction fetch side
   logic            if_valid;
   logic [XLEN-1:0] if_addr;
   logic            if_done;
   logic [XLEN-1:0] if_inst;
   // load/store unit side
   logic            lsu_valid;
   logic            lsu_we;
   logic [XLEN-1:0] lsu_addr;
   logic [DLEN-1:0] lsu_wdata;
   logic            lsu_done;
   logic [DLEN-1:0] lsu_rdata;
   // memory controller side
   logic            mem_valid;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [DLEN-1:0] mem_wdata;
   logic            mem_done;
   logic [DLEN-1:0] mem_rdata;
   // status
   logic            err;

   modport slave (
      input  if_valid, if_addr, lsu_valid, lsu_we, lsu_addr, lsu_wdata,
             mem_done, mem_rdata,
      output if_done, if_inst, lsu_done, lsu_rdata,
             mem_valid, mem_we, mem_addr, mem_wdata, err
   );

   modport master (
      output if_valid, if_addr, lsu_valid, lsu_we, lsu_addr, lsu_wdata,
             mem_done, mem_rdata,
      input  if_done, if_inst, lsu_done, lsu_rdata,
             mem_valid, mem_we, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory-controller port between instruction fetch (read only)
// and the load/store unit (read/write). Each client's request pulse is
// latched into a pending slot. Grants go round-robin, one transaction is
// in flight at a time, and each completion is routed back to its owner.
// Assumes XLEN <= DLEN, because the fetched word is taken from the low
// XLEN bits of the read data.
module mem_arbiter #(
   parameter int XLEN = 32,
   parameter int DLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic { S_IDLE, S_WAIT } state_e;
   typedef enum logic { OWN_IF, OWN_LSU } owner_e;

   // pending request slots
   logic            if_pend_q,  if_pend_d;
   logic [XLEN-1:0] if_addr_q,  if_addr_d;
   logic            lsu_pend_q, lsu_pend_d;
   logic            lsu_we_q,   lsu_we_d;
   logic [XLEN-1:0] lsu_addr_q, lsu_addr_d;
   logic [DLEN-1:0] lsu_wdata_q, lsu_wdata_d;
   logic            err_q,      err_d;

   // FSM state and registered outputs
   state_e          state_q;
   owner_e          owner_q;
   owner_e          last_grant_q;
   logic            mem_valid_q;
   logic            mem_we_q;
   logic [XLEN-1:0] mem_addr_q;
   logic [DLEN-1:0] mem_wdata_q;
   logic            if_done_q;
   logic [XLEN-1:0] if_inst_q;
   logic            lsu_done_q;
   logic [DLEN-1:0] lsu_rdata_q;

   // A completion frees its owner's slot on the same edge that raises the done pulse.
   logic done_fire, if_clr, lsu_clr, grant_lsu;
   assign done_fire = (state_q == S_WAIT) && bus.mem_done;
   assign if_clr    = done_fire && (owner_q == OWN_IF);
   assign lsu_clr   = done_fire && (owner_q == OWN_LSU);

   // LSU wins if it is the only one waiting, or if IF was served last.
   assign grant_lsu = lsu_pend_q && (!if_pend_q || (last_grant_q == OWN_IF));

   // Next-state of the pending slots: capture new pulses, drop duplicates and flag them.
   always_comb begin
      // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
      if_pend_d   = if_pend_q;
      if_addr_d   = if_addr_q;
      lsu_pend_d  = lsu_pend_q;
      lsu_we_d    = lsu_we_q;
      lsu_addr_d  = lsu_addr_q;
      lsu_wdata_d = lsu_wdata_q;
      err_d       = err_q;

      if (if_clr)  if_pend_d  = 1'b0;
      if (lsu_clr) lsu_pend_d = 1'b0;

      if (bus.if_valid) begin
         if (if_pend_q && !if_clr) begin
            err_d = 1'b1;
         end else begin
            if_pend_d = 1'b1;
            if_addr_d = bus.if_addr;
         end
      end

      if (bus.lsu_valid) begin
         if (lsu_pend_q && !lsu_clr) begin
            err_d = 1'b1;
         end else begin
            lsu_pend_d  = 1'b1;
            lsu_we_d    = bus.lsu_we;
            lsu_addr_d  = bus.lsu_addr;
            lsu_wdata_d = bus.lsu_wdata;
         end
      end
   end

   // Register the pending slots and the sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_pend_q   <= 1'b0;
         if_addr_q   <= '0;
         lsu_pend_q  <= 1'b0;
         lsu_we_q    <= 1'b0;
         lsu_addr_q  <= '0;
         lsu_wdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         if_pend_q   <= if_pend_d;
         if_addr_q   <= if_addr_d;
         lsu_pend_q  <= lsu_pend_d;
         lsu_we_q    <= lsu_we_d;
         lsu_addr_q  <= lsu_addr_d;
         lsu_wdata_q <= lsu_wdata_d;
         err_q       <= err_d;
      end
   end

   // Issue/complete FSM: grant from IDLE, wait for mem_done, then route the result back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         last_grant_q <= OWN_LSU;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_done_q    <= 1'b0;
         if_inst_q    <= '0;
         lsu_done_q   <= 1'b0;
         lsu_rdata_q  <= '0;
      end else begin
         mem_valid_q <= 1'b0;
         if_done_q   <= 1'b0;
         lsu_done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (if_pend_q || lsu_pend_q) begin
                  mem_valid_q <= 1'b1;
                  state_q     <= S_WAIT;
                  if (grant_lsu) begin
                     owner_q     <= OWN_LSU;
                     mem_we_q    <= lsu_we_q;
                     mem_addr_q  <= lsu_addr_q;
                     mem_wdata_q <= lsu_wdata_q;
                  end else begin
                     owner_q     <= OWN_IF;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr_q;
                     mem_wdata_q <= '0;
                  end
               end
            end
            S_WAIT: begin
               if (bus.mem_done) begin
                  last_grant_q <= owner_q;
                  state_q      <= S_IDLE;
                  if (owner_q == OWN_IF) begin
                     if_done_q <= 1'b1;
                     if_inst_q <= bus.mem_rdata[XLEN-1:0];
                  end else begin
                     lsu_done_q  <= 1'b1;
                     lsu_rdata_q <= bus.mem_rdata;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.if_inst   = if_inst_q;
   assign bus.lsu_done  = lsu_done_q;
   assign bus.lsu_rdata = lsu_rdata_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Expected memory transactions and expected
// completions are queued when requests are driven. A memory responder and a
// done monitor pop those queues and compare as the DUT produces output.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
module tb_mem_arbiter;

   localparam int XLEN = 32;
   localparam int DLEN = 32;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } mem_txn_t;

   typedef struct packed {
      logic        chk_data;
      logic [31:0] data;
   } done_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.XLEN(XLEN), .DLEN(DLEN)) bus ();

   mem_arbiter #(.XLEN(XLEN), .DLEN(DLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mem_txn_t  exp_mem[$];
   done_exp_t exp_if[$];
   done_exp_t exp_lsu[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_mv    = 0;
   int n_if_done  = 0;
   int n_lsu_done = 0;
   int if_done_cyc  = 0;
   int lsu_done_cyc = 0;
   int mv_cyc[$];
   int md_cyc[$];
   int resp_lat = 3;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic void exp_if_rd(input logic [31:0] addr, input logic [31:0] rdata);
      exp_mem.push_back('{we: 1'b0, addr: addr, wdata: 32'h0, rdata: rdata});
      exp_if.push_back('{chk_data: 1'b1, data: rdata});
   endfunction

   function automatic void exp_lsu_txn(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [31:0] rdata);
      exp_mem.push_back('{we: we, addr: addr, wdata: wdata, rdata: rdata});
      exp_lsu.push_back('{chk_data: !we, data: rdata});
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // Memory controller model: checks each issued request against the scoreboard
   // and answers resp_lat cycles later.
   initial begin : responder
      mem_txn_t e;
      logic [31:0] rd;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_valid === 1'b1) begin
            n_mv++;
            mv_cyc.push_back(cyc);
            if (exp_mem.size() == 0) begin
               check("mem_valid_unexpected", 32'd1, 32'd0);
               rd = 32'hBAD0_0BAD;
            end else begin
               e = exp_mem.pop_front();
               check("mem_we",   {31'd0, bus.mem_we}, {31'd0, e.we});
               check("mem_addr", bus.mem_addr, e.addr);
               if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
               rd = e.rdata;
            end
            repeat (resp_lat) @(posedge clk);
            #1;
            bus.mem_done  = 1'b1;
            bus.mem_rdata = rd;
            md_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            bus.mem_done  = 1'b0;
            bus.mem_rdata = $urandom;
         end
      end
   end

   // Completion monitor: pops the per-owner queues on each done pulse.
   always @(negedge clk) begin : done_mon
      done_exp_t d;
      if (bus.if_done === 1'b1) begin
         n_if_done++;
         if_done_cyc = cyc;
         check("done_overlap", {31'd0, bus.lsu_done}, 32'd0);
         if (exp_if.size() == 0) check("if_done_unexpected", 32'd1, 32'd0);
         else begin
            d = exp_if.pop_front();
            if (d.chk_data) check("if_inst", bus.if_inst, d.data);
         end
      end
      if (bus.lsu_done === 1'b1) begin
         n_lsu_done++;
         lsu_done_cyc = cyc;
         if (exp_lsu.size() == 0) check("lsu_done_unexpected", 32'd1, 32'd0);
         else begin
            d = exp_lsu.pop_front();
            if (d.chk_data) check("lsu_rdata", bus.lsu_rdata, d.data);
         end
      end
   end

   // Drive one cycle of request pulses; called 1 ns after a rising edge.
   task automatic pulse(input logic do_if, input logic [31:0] if_a,
                        input logic do_lsu, input logic we, input logic [31:0] lsu_a,
                        input logic [31:0] wd);
      bus.if_valid  = do_if;
      bus.if_addr   = if_a;
      bus.lsu_valid = do_lsu;
      bus.lsu_we    = we;
      bus.lsu_addr  = lsu_a;
      bus.lsu_wdata = wd;
      @(posedge clk);
      #1;
      bus.if_valid  = 1'b0;
      bus.lsu_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int k = 0;
      while ((n_if_done + n_lsu_done) < target && k < 300) begin
         @(posedge clk);
         k++;
      end
      #1;
      if ((n_if_done + n_lsu_done) < target)
         check(tag, n_if_done + n_lsu_done, target);
   endtask

   task automatic wait_mv(input int target, input string tag);
      int k = 0;
      while (n_mv < target && k < 300) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (n_mv < target) check(tag, n_mv, target);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int req_cyc, idx, base_if, base_lsu, base_mv, k;
      int if_sent, lsu_sent, seen_if, seen_lsu;
      bus.if_valid  = 1'b0;
      bus.if_addr   = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_we    = 1'b0;
      bus.lsu_addr  = '0;
      bus.lsu_wdata = '0;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      check("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_addr",  bus.mem_addr, 32'd0);
      check("rst_if_done",   {31'd0, bus.if_done}, 32'd0);
      check("rst_lsu_done",  {31'd0, bus.lsu_done}, 32'd0);
      check("rst_if_inst",   bus.if_inst, 32'd0);
      check("rst_lsu_rdata", bus.lsu_rdata, 32'd0);
      check("rst_err",       {31'd0, bus.err}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: IF only, latency 2 to mem_valid, 1 from mem_done to if_done
      resp_lat = 3;
      exp_if_rd(32'h40, 32'h00A00093);
      req_cyc = cyc;
      pulse(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_done(1, "t1_timeout");
      check("t1_mem_valid_lat", mv_cyc[mv_cyc.size()-1] - req_cyc, 32'd2);
      check("t1_if_done_lat", if_done_cyc - md_cyc[md_cyc.size()-1], 32'd1);
      check("t1_if_inst_hold", bus.if_inst, 32'h00A00093);

      // 2: tie after reset, IF first, LSU issued 2 cycles after IF's mem_done
      apply_reset();
      idx = n_mv;
      exp_if_rd(32'h0, 32'h1234_5678);
      exp_lsu_txn(1'b0, 32'h100, 32'h0, 32'hCAFE_0100);
      pulse(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
      wait_done(n_if_done + n_lsu_done + 2, "t2_timeout");
      check("t2_second_grant_gap", mv_cyc[idx+1] - md_cyc[idx], 32'd2);
      check("t2_if_before_lsu", {31'd0, (if_done_cyc < lsu_done_cyc)}, 32'd1);

      // 3: LSU write
      base_if  = n_if_done;
      base_lsu = n_lsu_done;
      exp_lsu_txn(1'b1, 32'h200, 32'hDEADBEEF, 32'h0);
      pulse(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
      wait_done(n_if_done + n_lsu_done + 1, "t3_timeout");
      repeat (3) @(posedge clk);
      #1;
      check("t3_lsu_done_cnt", n_lsu_done - base_lsu, 32'd1);
      check("t3_if_done_cnt",  n_if_done - base_if, 32'd0);

      // 4: fairness, both re-request right after each done, strict alternation
      for (int i = 0; i < 3; i++) begin
         exp_if_rd(32'h1000 + 32'(4*i), 32'h1100_0000 + 32'(i));
         exp_lsu_txn(1'b0, 32'h2000 + 32'(4*i), 32'h0, 32'h2200_0000 + 32'(i));
      end
      base_if  = n_if_done;
      base_lsu = n_lsu_done;
      seen_if  = n_if_done;
      seen_lsu = n_lsu_done;
      if_sent  = 1;
      lsu_sent = 1;
      pulse(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0);
      k = 0;
      while ((n_if_done - base_if + n_lsu_done - base_lsu) < 6 && k < 400) begin
         bus.if_valid  = 1'b0;
         bus.lsu_valid = 1'b0;
         if (n_if_done > seen_if) begin
            seen_if++;
            if (if_sent < 3) begin
               bus.if_valid = 1'b1;
               bus.if_addr  = 32'h1000 + 32'(4*if_sent);
               if_sent++;
            end
         end
         if (n_lsu_done > seen_lsu) begin
            seen_lsu++;
            if (lsu_sent < 3) begin
               bus.lsu_valid = 1'b1;
               bus.lsu_we    = 1'b0;
               bus.lsu_addr  = 32'h2000 + 32'(4*lsu_sent);
               lsu_sent++;
            end
         end
         @(posedge clk);
         #1;
         k++;
      end
      bus.if_valid  = 1'b0;
      bus.lsu_valid = 1'b0;
      check("t4_if_grants",  n_if_done - base_if, 32'd3);
      check("t4_lsu_grants", n_lsu_done - base_lsu, 32'd3);
      check("t4_err", {31'd0, bus.err}, 32'd0);

      // 5: double LSU request while pending -> err, one issue, first address kept
      base_mv = n_mv;
      exp_lsu_txn(1'b0, 32'h300, 32'h0, 32'h3333_3333);
      pulse(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
      pulse(1'b0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0);
      wait_done(n_if_done + n_lsu_done + 1, "t5_timeout");
      repeat (5) @(posedge clk);
      #1;
      check("t5_issue_cnt", n_mv - base_mv, 32'd1);
      check("t5_err", {31'd0, bus.err}, 32'd1);

      // 6: reset during WAIT, late mem_done must be ignored
      resp_lat = 8;
      base_mv  = n_mv;
      base_if  = n_if_done;
      base_lsu = n_lsu_done;
      exp_mem.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, rdata: 32'h5555_5555});
      pulse(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_mv(base_mv + 1, "t6_issue_timeout");
      rst_n = 1'b0;
      #1;
      check("t6_rst_err", {31'd0, bus.err}, 32'd0);
      check("t6_rst_mem_addr", bus.mem_addr, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("t6_if_done_cnt",  n_if_done - base_if, 32'd0);
      check("t6_lsu_done_cnt", n_lsu_done - base_lsu, 32'd0);
      check("t6_issue_cnt",    n_mv - base_mv, 32'd1);
      check("t6_err",          {31'd0, bus.err}, 32'd0);
      resp_lat = 3;
      exp_lsu_txn(1'b0, 32'h600, 32'h0, 32'h6666_6666);
      req_cyc = cyc;
      pulse(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0);
      wait_done(n_if_done + n_lsu_done + 1, "t6_post_timeout");
      check("t6_idle_lat", mv_cyc[mv_cyc.size()-1] - req_cyc, 32'd2);

      repeat (3) @(posedge clk);
      #1;
      check("left_exp_mem", exp_mem.size(), 32'd0);
      check("left_exp_if",  exp_if.size(), 32'd0);
      check("left_exp_lsu", exp_lsu.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
